serial_subtraction: RTL and testbench

//  Sequential counterpart to the parallel ripple adder: computes Y = A - B one bit per clock, LSB first.

---
 rtl/serial_subtraction_pkg.sv | 18 +
 rtl/serial_subtraction_if.sv | 24 ++
 rtl/serial_subtraction_fs.sv | 14 +
 rtl/serial_subtraction.sv | 80 ++++++++
 tb/tb_serial_subtraction.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/serial_subtraction_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// full-subtractor equations used by the single-bit cell.
package serial_subtraction_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Returns {bout, d} for a - b - bin.
    function automatic logic [1:0] fs_eval(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, d};
    endfunction

endpackage

// File: rtl/serial_subtraction_if.sv
// Start/busy/valid handshake bundle between a controller and the serial subtractor.
// Y carries {borrow, difference}.
interface serial_subtraction_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_ready;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   Y;

    modport master (
        output start, A, B, out_ready,
        input  in_ready, busy, out_valid, Y
    );

    modport slave (
        input  start, A, B, out_ready,
        output in_ready, busy, out_valid, Y
    );
endinterface

// File: rtl/serial_subtraction_fs.sv
// Combinational single-bit full subtractor, the subtract-side peer of the full adder cell.
module full_subtractor
    import serial_subtraction_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign {o_bout, o_diff} = fs_eval(i_a, i_b, i_bin);

endmodule

// File: rtl/serial_subtraction.sv
// Bit-serial Y = A - B, LSB first, one bit per clock through a single full subtractor.
// Difference bits enter Y from the top so the LSB lands in Y[0] after WIDTH steps.
module serial_subtraction
    import serial_subtraction_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    serial_subtraction_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_y;
    logic             w_d;
    logic             w_bout;

    full_subtractor u_fs (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_borrow),
        .o_diff (w_d),
        .o_bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_y      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_y      <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_y[WIDTH-1:0] <= {w_d, r_y[WIDTH-1:1]};
                    r_borrow       <= w_bout;
                    r_a            <= r_a >> 1;
                    r_b            <= r_b >> 1;
                    // Counter parks at WIDTH-1; it is reloaded on the next capture.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_y[WIDTH] <= w_bout;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.Y         = r_y;

endmodule

// File: tb/tb_serial_subtraction.sv
// Directed bench for serial_subtraction: handshake, latency, hold, abort and a full operand sweep.
module tb_serial_subtraction;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   n_both;

    serial_subtraction_if #(.WIDTH(W)) bus ();

    serial_subtraction #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.in_ready && bus.busy) n_both++;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Capture, scramble A/B afterwards, measure latency, check Y, hand off.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] exp, input bit full);
        int lat;
        wait_idle(tag);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = a ^ b;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (full) check({tag, "_lat"}, lat, 32'd4);
        check({tag, "_y"}, {27'd0, bus.Y}, {27'd0, exp});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        if (full) check({tag, "_vld_drop"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        n_both        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_y",         {27'd0, bus.Y},         32'd0);
        rst = 1'b0;
        tick();

        do_op("t1_9m3",   4'd9,  4'd3,  5'b0_0110, 1'b1);
        do_op("t2_3m9",   4'd3,  4'd9,  5'b1_1010, 1'b1);
        do_op("t2_0m1",   4'd0,  4'd1,  5'b1_1111, 1'b1);
        do_op("t3_15m15", 4'd15, 4'd15, 5'b0_0000, 1'b1);
        do_op("t3_0m0",   4'd0,  4'd0,  5'b0_0000, 1'b1);
        do_op("t3_15m0",  4'd15, 4'd0,  5'b0_1111, 1'b1);

        // Hold in DONE with out_ready low; start pulses during RUN/DONE are ignored.
        wait_idle("t4");
        bus.A = 4'd12; bus.B = 4'd5; bus.start = 1'b1;
        tick();
        bus.A = 4'd1; bus.B = 4'd14;
        tick();
        check("t4_busy_run", {31'd0, bus.busy}, 32'd1);
        repeat (3) tick();
        check("t4_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t4_y", {27'd0, bus.Y}, 32'h07);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_vld", {31'd0, bus.out_valid}, 32'd1);
            check("t4_hold_y", {27'd0, bus.Y}, 32'h07);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        check("t4_handoff_vld", {31'd0, bus.out_valid}, 32'd0);
        check("t4_handoff_idle", {31'd0, bus.in_ready}, 32'd1);
        check("t4_y_kept", {27'd0, bus.Y}, 32'h07);
        tick();
        check("t4_no_capture", {31'd0, bus.busy}, 32'd0);

        // Asynchronous abort two clocks after capture.
        bus.A = 4'd13; bus.B = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("t5_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_rst_vld", {31'd0, bus.out_valid}, 32'd0);
        check("t5_rst_y", {27'd0, bus.Y}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("t5_no_vld", {31'd0, bus.out_valid}, 32'd0);
        do_op("t5_7m2", 4'd7, 4'd2, 5'b0_0101, 1'b1);

        // Exhaustive sweep against an independent {A<B, A-B mod 16} model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [4:0] exp;
                exp[4]   = (a < b);
                exp[3:0] = 4'((a - b + 16) % 16);
                do_op("sweep", 4'(a), 4'(b), exp, 1'b0);
            end
        end
        check("ready_busy_exclusive", n_both, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
